mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and load/store: one transaction
// in flight, data-first priority with a fetch starvation guard and a watchdog abort.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);
    localparam int SV_W = $clog2(STARVE_LIM + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [SV_W-1:0] STARVE_MAX = SV_W'(STARVE_LIM);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} stateT;

    stateT             state;
    logic              ownerData;
    logic              memReqQ;
    logic              weQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [3:0]        beQ;
    logic              errQ;
    logic [SV_W-1:0]   starveCnt;
    logic [TO_W-1:0]   toCnt;

    logic fetchForced;
    logic grantData;
    logic respDone;
    logic timeoutHit;
    logic done;

    assign fetchForced = if_req && (starveCnt == STARVE_MAX);
    assign grantData   = d_req && !fetchForced;
    assign respDone    = (state == RESP) && mem_rvalid;
    // The watchdog fires on the TIMEOUT-th cycle spent in ADDR/RESP.
    assign timeoutHit  = (state != IDLE) && (toCnt == TO_LAST);
    assign done        = respDone || timeoutHit;

    assign if_ack    = done && !ownerData;
    assign d_ack     = done && ownerData;
    assign if_rdata  = (if_ack && respDone) ? mem_rdata : '0;
    assign d_rdata   = (d_ack && respDone) ? mem_rdata : '0;
    assign stall_if  = if_req && !if_ack;
    assign stall_mem = d_req && !d_ack;

    assign mem_req   = memReqQ;
    assign mem_we    = weQ;
    assign mem_addr  = addrQ;
    assign mem_wdata = wdataQ;
    assign mem_be    = beQ;
    assign err       = errQ || timeoutHit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ownerData <= 1'b0;
            memReqQ   <= 1'b0;
            weQ       <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            beQ       <= '0;
            errQ      <= 1'b0;
            starveCnt <= '0;
            toCnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req || if_req) begin
                        state     <= ADDR;
                        memReqQ   <= 1'b1;
                        toCnt     <= '0;
                        ownerData <= grantData;
                        if (grantData) begin
                            weQ    <= d_we;
                            addrQ  <= d_addr;
                            wdataQ <= d_wdata;
                            beQ    <= d_be;
                            if (if_req && (starveCnt != STARVE_MAX))
                                starveCnt <= starveCnt + 1'b1;
                        end else begin
                            weQ       <= 1'b0;
                            addrQ     <= if_addr;
                            wdataQ    <= '0;
                            beQ       <= 4'hF;
                            starveCnt <= '0;
                        end
                    end
                end
                ADDR: begin
                    toCnt <= toCnt + 1'b1;
                    if (timeoutHit) begin
                        state   <= IDLE;
                        memReqQ <= 1'b0;
                        errQ    <= 1'b1;
                    end else if (mem_gnt) begin
                        state   <= RESP;
                        memReqQ <= 1'b0;
                    end
                end
                RESP: begin
                    toCnt <= toCnt + 1'b1;
                    if (respDone) begin
                        state <= IDLE;
                    end else if (timeoutHit) begin
                        state <= IDLE;
                        errQ  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus
// hand-written starvation, timeout and reset sequences.
module tb_mem_port_arbiter;
    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIM(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        ir;  logic [31:0] ia;
        logic        dr;  logic        dw;  logic [31:0] da; logic [31:0] dd; logic [3:0] db;
        logic        g;   logic        rv;  logic [31:0] rd;
        logic        emr; logic        emw; logic [31:0] ema; logic [31:0] ewd; logic [3:0] emb;
        logic        eia; logic [31:0] eir; logic        eda; logic [31:0] edr;
        logic        esi; logic        esm;
    } vecT;

    vecT vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleIn();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic applyIn(input vecT v);
        if_req = v.ir; if_addr = v.ia;
        d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dd; d_be = v.db;
        mem_gnt = v.g; mem_rvalid = v.rv; mem_rdata = v.rd;
    endtask

    initial begin
        rst = 1'b1;
        idleIn();

        // ir  ia      dr dw da      dd            db    g  rv rd      | mr mw ma      wd            be    ia eir      da edr     si sm
        // fetch-only, minimum latency
        vecs.push_back('{1, 32'h100, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,    0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,    0, 32'h0,    1, 0});
        vecs.push_back('{1, 32'h100, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h0,    1, 0, 32'h100, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    1, 0});
        vecs.push_back('{1, 32'h100, 0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h13,   0, 0, 32'h100, 32'h0,        4'hF, 1, 32'h13,   0, 32'h0,    0, 0});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,    0, 0, 32'h100, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    0, 0});
        // simultaneous requests: store wins, fetch follows
        vecs.push_back('{1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 4'h3, 0, 0, 32'h0,    0, 0, 32'h100, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    1, 1});
        vecs.push_back('{1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 4'h3, 1, 0, 32'h0,    1, 1, 32'h200, 32'hDEADBEEF, 4'h3, 0, 32'h0,    0, 32'h0,    1, 1});
        vecs.push_back('{1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 4'h3, 0, 1, 32'h55,   0, 1, 32'h200, 32'hDEADBEEF, 4'h3, 0, 32'h0,    1, 32'h55,   1, 0});
        vecs.push_back('{1, 32'h104, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,    0, 1, 32'h200, 32'hDEADBEEF, 4'h3, 0, 32'h0,    0, 32'h0,    1, 0});
        vecs.push_back('{1, 32'h104, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h0,    1, 0, 32'h104, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    1, 0});
        vecs.push_back('{1, 32'h104, 0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 32'hA5A5, 0, 0, 32'h104, 32'h0,        4'hF, 1, 32'hA5A5, 0, 32'h0,    0, 0});
        // load with grant held off 3 cycles; stray rvalid in ADDR and gnt in RESP ignored
        vecs.push_back('{0, 32'h0,   1, 0, 32'h300, 32'h0,        4'hF, 0, 0, 32'h0,    0, 0, 32'h104, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    0, 1});
        vecs.push_back('{0, 32'h0,   1, 0, 32'h300, 32'h0,        4'hF, 0, 1, 32'h77,   1, 0, 32'h300, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    0, 1});
        vecs.push_back('{0, 32'h0,   1, 0, 32'h300, 32'h0,        4'hF, 0, 0, 32'h0,    1, 0, 32'h300, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    0, 1});
        vecs.push_back('{0, 32'h0,   1, 0, 32'h300, 32'h0,        4'hF, 0, 0, 32'h0,    1, 0, 32'h300, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    0, 1});
        vecs.push_back('{0, 32'h0,   1, 0, 32'h300, 32'h0,        4'hF, 1, 0, 32'h0,    1, 0, 32'h300, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    0, 1});
        vecs.push_back('{0, 32'h0,   1, 0, 32'h300, 32'h0,        4'hF, 1, 0, 32'h0,    0, 0, 32'h300, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    0, 1});
        vecs.push_back('{0, 32'h0,   1, 0, 32'h300, 32'h0,        4'hF, 0, 1, 32'h1234, 0, 0, 32'h300, 32'h0,        4'hF, 0, 32'h0,    1, 32'h1234, 0, 0});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0,    0, 0, 32'h300, 32'h0,        4'hF, 0, 32'h0,    0, 32'h0,    0, 0});

        // reset state
        @(posedge clk);
        @(posedge clk);
        #4;
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_be", mem_be, 0);
        chk("rst.if_ack", if_ack, 0);
        chk("rst.d_ack", d_ack, 0);
        chk("rst.err", err, 0);
        nextCycle();
        rst = 1'b0;

        foreach (vecs[i]) begin
            nextCycle();
            applyIn(vecs[i]);
            #3;
            chk($sformatf("v%0d.mem_req", i), mem_req, vecs[i].emr);
            chk($sformatf("v%0d.mem_we", i), mem_we, vecs[i].emw);
            chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].ema);
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].ewd);
            chk($sformatf("v%0d.mem_be", i), mem_be, vecs[i].emb);
            chk($sformatf("v%0d.if_ack", i), if_ack, vecs[i].eia);
            chk($sformatf("v%0d.if_rdata", i), if_rdata, vecs[i].eir);
            chk($sformatf("v%0d.d_ack", i), d_ack, vecs[i].eda);
            chk($sformatf("v%0d.d_rdata", i), d_rdata, vecs[i].edr);
            chk($sformatf("v%0d.stall_if", i), stall_if, vecs[i].esi);
            chk($sformatf("v%0d.stall_mem", i), stall_mem, vecs[i].esm);
            chk($sformatf("v%0d.err", i), err, 0);
        end

        // starvation: both request continuously; grants 1-4 data, 5th fetch, 6th data again
        for (int t = 0; t < 6; t++) begin
            nextCycle();
            idleIn();
            if_req = 1; if_addr = 32'h500;
            d_req = 1; d_we = 0; d_addr = 32'h400; d_be = 4'hF;
            nextCycle();
            mem_gnt = 1;
            #3;
            chk($sformatf("starve%0d.mem_addr", t), mem_addr, (t == 4) ? 32'h500 : 32'h400);
            nextCycle();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1000 + t;
            #3;
            chk($sformatf("starve%0d.d_ack", t), d_ack, (t != 4));
            chk($sformatf("starve%0d.if_ack", t), if_ack, (t == 4));
        end

        // timeout: grant given, no response ever comes
        nextCycle();
        idleIn();
        d_req = 1; d_addr = 32'h600; d_be = 4'hF; mem_rdata = 32'hFFFF_FFFF;
        #3;
        chk("to0.err", err, 0);
        for (int k = 1; k <= 8; k++) begin
            nextCycle();
            mem_gnt = (k == 1);
            #3;
            chk($sformatf("to%0d.d_ack", k), d_ack, (k == 8));
            chk($sformatf("to%0d.err", k), err, (k == 8));
            if (k == 8) chk("to8.d_rdata", d_rdata, 0);
        end
        nextCycle();
        d_req = 0; mem_rvalid = 1;
        #3;
        chk("to_late.d_ack", d_ack, 0);
        chk("to_late.mem_req", mem_req, 0);
        chk("to_late.err", err, 1);
        for (int k = 0; k < 2; k++) begin
            nextCycle();
            mem_rvalid = 0;
            #3;
            chk($sformatf("to_sticky%0d.err", k), err, 1);
        end

        // reset asserted while waiting in RESP
        nextCycle();
        idleIn();
        d_req = 1; d_we = 1; d_addr = 32'h700; d_wdata = 32'h11; d_be = 4'h1;
        nextCycle();
        mem_gnt = 1;
        #3;
        chk("rr.mem_req_addr", mem_req, 1);
        nextCycle();
        mem_gnt = 0;
        #1;
        rst = 1; d_req = 0;
        #2;
        chk("rr.mem_req", mem_req, 0);
        chk("rr.mem_we", mem_we, 0);
        chk("rr.mem_addr", mem_addr, 0);
        chk("rr.mem_wdata", mem_wdata, 0);
        chk("rr.mem_be", mem_be, 0);
        chk("rr.d_ack", d_ack, 0);
        chk("rr.err", err, 0);
        chk("rr.stall_mem", stall_mem, 0);
        nextCycle();
        rst = 0;
        nextCycle();
        mem_rvalid = 1; mem_rdata = 32'h99;
        #3;
        chk("rr_late.d_ack", d_ack, 0);
        chk("rr_late.if_ack", if_ack, 0);
        chk("rr_late.d_rdata", d_rdata, 0);
        nextCycle();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h800;
        #3;
        chk("rr_new.mem_req_idle", mem_req, 0);
        chk("rr_new.stall_if", stall_if, 1);
        nextCycle();
        mem_gnt = 1;
        #3;
        chk("rr_new.mem_req", mem_req, 1);
        chk("rr_new.mem_addr", mem_addr, 32'h800);
        nextCycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h42;
        #3;
        chk("rr_new.if_ack", if_ack, 1);
        chk("rr_new.if_rdata", if_rdata, 32'h42);
        chk("rr_new.d_ack", d_ack, 0);
        nextCycle();
        idleIn();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
